l2_cache: RTL and testbench
===========================

L2_CACHE -- requirements
Module: l2_cache

Interface
REQ-001 Parameter: ENTRY_NUM, 8, number of direct-mapped lines (power of two, 2..64).
REQ-002 Parameter: LINE_W, 128, line width in bits.
REQ-003 Parameter: ADDR_W, 28, line-address width.
REQ-004 Port: clk  in  1  single clock, all logic on posedge.
REQ-005 Port: proc_reset  in  1  reset, synchronous, active-high.
REQ-006 Port: proc_read  in  1  L1 line-fill request, held until proc_ready seen.
REQ-007 Port: proc_write  in  1  L1 line write-back request, held until proc_ready seen.
REQ-008 Port: proc_addr  in  ADDR_W  line address.
REQ-009 Port: proc_wdata  in  LINE_W  write-back line.
REQ-010 Port: proc_rdata  out  LINE_W  fill line, valid while proc_ready=1.
REQ-011 Port: proc_ready  out  1  one-cycle completion pulse, registered.
REQ-012 Port: mem_read / mem_write  out  1 each  memory requests, registered.
REQ-013 Port: mem_addr  out  ADDR_W  memory line address; mem_wdata  out  LINE_W  victim line.
REQ-014 Port: mem_rdata  in  LINE_W; mem_ready  in  1  one-cycle memory completion pulse.

Function
REQ-015 Address split: index = proc_addr[log2(ENTRY_NUM)-1:0]; tag = remaining upper bits; hit = valid[index] && tag match.
REQ-016 FSM states IDLE, COMPARE, WRITEBACK, ALLOCATE; reset state IDLE.
REQ-017 IDLE: request accepted -> COMPARE only when (proc_read||proc_write) && !proc_ready; requests are ignored in the cycle proc_ready=1.
REQ-018 proc_read && proc_write together: write has priority.
REQ-019 COMPARE read hit: proc_rdata <= line, proc_ready <= 1, -> IDLE; hit latency = 2 cycles from request to proc_ready.
REQ-020 COMPARE write (hit, or miss with victim clean/invalid): line <= proc_wdata, tag/valid/dirty <= tag/1/1, proc_ready <= 1, -> IDLE; no memory fetch on a write.
REQ-021 COMPARE miss, victim valid && dirty: -> WRITEBACK; victim clean/invalid on read miss: -> ALLOCATE.
REQ-022 WRITEBACK: mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim line, held stable until mem_ready; then dirty[index] <= 0, mem_write <= 0; read -> ALLOCATE, write -> COMPARE.
REQ-023 ALLOCATE: mem_read=1, mem_addr=proc_addr held until mem_ready; then line <= mem_rdata, tag set, valid=1, dirty=0, mem_read <= 0, -> COMPARE (guaranteed hit).
REQ-024 mem_read and mem_write are never asserted simultaneously; both are low in IDLE and COMPARE.
REQ-025 proc_rdata holds its last value when proc_ready=0; proc_ready high for exactly one cycle per request.

Reset
REQ-026 proc_reset, including mid-WRITEBACK/ALLOCATE, forces on the next edge: state=IDLE, all valid/dirty=0, proc_ready=0, proc_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0; the in-flight transfer is abandoned.
REQ-027 Data/tag arrays are cleared to 0 on reset.

Configuration
REQ-028 Macro L2_PERF_CNT_EN defined: adds outputs hit_cnt[15:0], miss_cnt[15:0], counted once per COMPARE entry from IDLE, saturating at 16'hFFFF, reset to 0.
REQ-029 Macro L2_PERF_CNT_EN undefined: no counter ports or logic; all other behaviour identical.

Structure
REQ-030 Package l2_pkg holds: state enum, LINE_W, ADDR_W defaults, derived INDEX_W/TAG_W functions.
REQ-031 Sub-module l2_line_store holds the data/tag/valid/dirty arrays with one write port and combinational read by index; the FSM resides in l2_cache.

Verification
REQ-032 Cold read addr 28'h0000010 -> mem_read with mem_addr 28'h0000010; mem_ready with rdata 128'hA5..A5 -> proc_ready pulse, proc_rdata=128'hA5..A5.
REQ-033 Repeat read 28'h0000010 -> proc_ready exactly 2 cycles after request, no mem_read.
REQ-034 Write 28'h0000018 data D1, then read 28'h0000028 (same index 0) -> mem_write addr 28'h0000018 data D1, then mem_read 28'h0000028.
REQ-035 Request held high through proc_ready cycle -> exactly one proc_ready pulse, no second accept.
REQ-036 proc_reset asserted during ALLOCATE -> mem_read low next cycle; subsequent read of same address misses again.
REQ-037 With L2_PERF_CNT_EN: scenario REQ-032..034 sequence -> hit_cnt=1, miss_cnt=3.

Source files
------------

// File: rtl/l2_pkg.sv
// Shared types and sizing helpers for the direct-mapped L2 cache.
package l2_pkg;

  localparam int unsigned L2_LINE_W = 128;
  localparam int unsigned L2_ADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } l2_state_e;

  function automatic int unsigned index_w(input int unsigned entry_num);
    return $clog2(entry_num);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned entry_num);
    return addr_w - $clog2(entry_num);
  endfunction

endpackage

// File: rtl/l2_line_store.sv
// Line storage: data/tag/valid/dirty arrays, one write port, combinational read by index.
module l2_line_store
  import l2_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = 8,
  parameter int unsigned LINE_W    = L2_LINE_W,
  parameter int unsigned INDEX_W   = index_w(ENTRY_NUM),
  parameter int unsigned TAG_W     = tag_w(L2_ADDR_W, ENTRY_NUM)
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic [LINE_W-1:0]  rd_data_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic               rd_valid_o,
  output logic               rd_dirty_o,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [LINE_W-1:0]  wr_data_i,
  input  logic               wr_dirty_i
);

  logic [LINE_W-1:0]    data_q [ENTRY_NUM];
  logic [TAG_W-1:0]     tag_q  [ENTRY_NUM];
  logic [ENTRY_NUM-1:0] valid_q;
  logic [ENTRY_NUM-1:0] dirty_q;

  // Every write installs a live line, so valid is set unconditionally.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      data_q[wr_idx_i]  <= wr_data_i;
      tag_q[wr_idx_i]   <= wr_tag_i;
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= wr_dirty_i;
    end
  end

  assign rd_data_o  = data_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];

endmodule

// File: rtl/l2_cache.sv
// Direct-mapped write-back L2 cache controller between an L1 and line-wide memory.
// Optional hit/miss counters are enabled by defining L2_PERF_CNT_EN.
module l2_cache
  import l2_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = 8,
  parameter int unsigned LINE_W    = L2_LINE_W,
  parameter int unsigned ADDR_W    = L2_ADDR_W
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [LINE_W-1:0] proc_wdata,
  output logic [LINE_W-1:0] proc_rdata,
  output logic              proc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef L2_PERF_CNT_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  localparam int unsigned INDEX_W = index_w(ENTRY_NUM);
  localparam int unsigned TAG_W   = tag_w(ADDR_W, ENTRY_NUM);

  // state     | meaning
  // IDLE      | waiting for an L1 request
  // COMPARE   | tag lookup, hit completion or miss dispatch
  // WRITEBACK | dirty victim being written to memory
  // ALLOCATE  | requested line being fetched from memory
  l2_state_e state_q, state_d;

  logic [LINE_W-1:0] proc_rdata_q, proc_rdata_d;
  logic              proc_ready_q, proc_ready_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [LINE_W-1:0]  rd_data;
  logic [TAG_W-1:0]   rd_tag;
  logic               rd_valid, rd_dirty, hit;

  logic               st_we, st_dirty;
  logic [TAG_W-1:0]   st_tag;
  logic [LINE_W-1:0]  st_data;

  assign req_idx = proc_addr[INDEX_W-1:0];
  assign req_tag = proc_addr[ADDR_W-1:INDEX_W];
  assign hit     = rd_valid && (rd_tag == req_tag);

  l2_line_store #(
    .ENTRY_NUM (ENTRY_NUM),
    .LINE_W    (LINE_W),
    .INDEX_W   (INDEX_W),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk        (clk),
    .rst_i      (proc_reset),
    .rd_idx_i   (req_idx),
    .rd_data_o  (rd_data),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .we_i       (st_we),
    .wr_idx_i   (req_idx),
    .wr_tag_i   (st_tag),
    .wr_data_i  (st_data),
    .wr_dirty_i (st_dirty)
  );

  always_comb begin
    state_d      = state_q;
    proc_rdata_d = proc_rdata_q;
    proc_ready_d = 1'b0;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    st_we        = 1'b0;
    st_tag       = req_tag;
    st_data      = proc_wdata;
    st_dirty     = 1'b1;

    unique case (state_q)
      IDLE: begin
        if ((proc_read || proc_write) && !proc_ready_q) state_d = COMPARE;
      end
      COMPARE: begin
        if ((proc_write || !hit) && rd_valid && rd_dirty && !hit) begin
          state_d     = WRITEBACK;
          mem_write_d = 1'b1;
          mem_addr_d  = {rd_tag, req_idx};
          mem_wdata_d = rd_data;
        end else if (proc_write) begin
          st_we        = 1'b1;
          proc_ready_d = 1'b1;
          state_d      = IDLE;
        end else if (hit) begin
          proc_rdata_d = rd_data;
          proc_ready_d = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d    = ALLOCATE;
          mem_read_d = 1'b1;
          mem_addr_d = proc_addr;
        end
      end
      WRITEBACK: begin
        if (mem_ready) begin
          mem_write_d = 1'b0;
          // Re-store the victim unchanged except for its dirty bit.
          st_we    = 1'b1;
          st_tag   = rd_tag;
          st_data  = rd_data;
          st_dirty = 1'b0;
          if (proc_write) begin
            state_d = COMPARE;
          end else begin
            state_d    = ALLOCATE;
            mem_read_d = 1'b1;
            mem_addr_d = proc_addr;
          end
        end
      end
      ALLOCATE: begin
        if (mem_ready) begin
          mem_read_d = 1'b0;
          st_we      = 1'b1;
          st_data    = mem_rdata;
          st_dirty   = 1'b0;
          state_d    = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q      <= IDLE;
      proc_rdata_q <= '0;
      proc_ready_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      proc_rdata_q <= proc_rdata_d;
      proc_ready_q <= proc_ready_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign proc_rdata = proc_rdata_q;
  assign proc_ready = proc_ready_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

`ifdef L2_PERF_CNT_EN
  logic        first_q;
  logic [15:0] hit_cnt_q, miss_cnt_q;

  // Only the lookup that directly follows acceptance is counted; re-entries after a fill are not.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      first_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      first_q <= (state_q == IDLE) && (state_d == COMPARE);
      if (state_q == COMPARE && first_q) begin
        if (hit) begin
          if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
        end else begin
          if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l2_cache.sv
// Directed bench for l2_cache with a transaction-level cache/memory model and a per-cycle checker.
module tb_l2_cache;

  logic         clk = 1'b0;
  logic         proc_reset, proc_read, proc_write;
  logic [27:0]  proc_addr;
  logic [127:0] proc_wdata, proc_rdata;
  logic         proc_ready, mem_read, mem_write, mem_ready;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
`ifdef L2_PERF_CNT_EN
  logic [15:0]  hit_cnt, miss_cnt;
`endif

  l2_cache dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_ready (proc_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef L2_PERF_CNT_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Cache model: per-index valid/dirty/tag/line; world memory with a default pattern.
  bit           mv [8];
  bit           md [8];
  logic [24:0]  mt [8];
  logic [127:0] mdat [8];
  logic [127:0] world [logic [27:0]];

  bit           chk_off, req_active, exp_is_read, exp_wb_pending, exp_fill_pending, prev_ready;
  logic [27:0]  exp_wb_addr, exp_fill_addr, seen_wb_addr, seen_fill_addr;
  logic [127:0] exp_wb_data, exp_rdata, last_rdata, seen_wb_data, got_rdata;
  int           lat;

  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] D1 = {4{32'hD1D1_0001}};
  localparam logic [127:0] D2 = {4{32'hD2D2_0002}};
  localparam logic [127:0] D3 = {4{32'hD3D3_0003}};
  localparam logic [127:0] D4 = {4{32'hD4D4_0004}};
  localparam logic [127:0] D5 = {4{32'hD5D5_0005}};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] wval(input logic [27:0] a);
    if (world.exists(a)) return world[a];
    return {4{a, 4'h5}};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 8; k++) begin
      mv[k] = 1'b0; md[k] = 1'b0; mt[k] = '0; mdat[k] = '0;
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (chk_off) begin
        prev_ready = 1'b0;
        last_rdata = '0;
      end else begin
        chk("mem_rd_wr_excl", 128'(mem_read && mem_write), 128'd0);
        if (mem_write) begin
          chk("wb_expected", 128'(exp_wb_pending), 128'd1);
          chk("wb_addr", 128'(mem_addr), 128'(exp_wb_addr));
          chk("wb_data", mem_wdata, exp_wb_data);
        end
        if (mem_read) begin
          chk("fill_expected", 128'(exp_fill_pending && !exp_wb_pending), 128'd1);
          chk("fill_addr", 128'(mem_addr), 128'(exp_fill_addr));
        end
        if (proc_ready) begin
          chk("ready_expected", 128'(req_active && !prev_ready), 128'd1);
          if (exp_is_read) begin
            chk("rdata", proc_rdata, exp_rdata);
            last_rdata = exp_rdata;
          end
        end else begin
          chk("rdata_hold", proc_rdata, last_rdata);
        end
        prev_ready = proc_ready;
      end
    end
  endtask

  task automatic do_req(input string nm, input bit wr, input bit rd,
                        input logic [27:0] a, input logic [127:0] d);
    int unsigned i;
    logic [24:0] t;
    bit hit, got, r_rd, r_wr;
    int cyc, wcnt, nrd, nwr, exp_rd, exp_wr;
    i = int'(a % 28'd8);
    t = 25'(a / 28'd8);
    hit = mv[i] && (mt[i] == t);
    exp_wb_pending   = !hit && mv[i] && md[i];
    exp_wb_addr      = 28'(mt[i]) * 28'd8 + 28'(i);
    exp_wb_data      = mdat[i];
    exp_is_read      = !wr;
    exp_fill_pending = !wr && !hit;
    exp_fill_addr    = a;
    exp_wr = exp_wb_pending ? 1 : 0;
    exp_rd = exp_fill_pending ? 1 : 0;
    if (wr) begin
      mv[i] = 1'b1; md[i] = 1'b1; mt[i] = t; mdat[i] = d;
    end else if (hit) begin
      exp_rdata = mdat[i];
    end else begin
      exp_rdata = wval(a);
      mv[i] = 1'b1; md[i] = 1'b0; mt[i] = t; mdat[i] = exp_rdata;
    end

    req_active = 1'b1;
    proc_addr = a; proc_wdata = d; proc_write = wr; proc_read = rd;
    cyc = 0; wcnt = 0; nrd = 0; nwr = 0; got = 1'b0; r_rd = 1'b0; r_wr = 1'b0; lat = -1;
    while (!got && cyc < 100) begin
      @(negedge clk);
      if (proc_ready) begin
        got = 1'b1;
        lat = cyc;
        got_rdata = proc_rdata;
      end else if ((mem_read || mem_write) && !mem_ready) begin
        wcnt++;
        if (wcnt == 2) begin
          wcnt = 0;
          mem_ready = 1'b1;
          if (mem_read) begin
            mem_rdata = wval(mem_addr);
            seen_fill_addr = mem_addr;
            r_rd = 1'b1;
          end else begin
            world[mem_addr] = mem_wdata;
            seen_wb_addr = mem_addr;
            seen_wb_data = mem_wdata;
            r_wr = 1'b1;
          end
        end
      end
      @(posedge clk); #1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        if (r_rd) begin exp_fill_pending = 1'b0; nrd++; end
        if (r_wr) begin exp_wb_pending = 1'b0; nwr++; end
        r_rd = 1'b0; r_wr = 1'b0;
      end
      cyc++;
    end
    proc_read = 1'b0; proc_write = 1'b0;
    req_active = 1'b0;
    chk({nm, "_done"}, 128'(got), 128'd1);
    chk({nm, "_mem_reads"}, 128'(nrd), 128'(exp_rd));
    chk({nm, "_mem_writes"}, 128'(nwr), 128'(exp_wr));
    if (exp_rd == 0 && exp_wr == 0) chk({nm, "_latency"}, 128'(lat), 128'd2);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wc;
    bit seen;
    chk_off = 1'b1; req_active = 1'b0; exp_is_read = 1'b0;
    exp_wb_pending = 1'b0; exp_fill_pending = 1'b0; prev_ready = 1'b0;
    exp_wb_addr = '0; exp_fill_addr = '0; exp_wb_data = '0; exp_rdata = '0; last_rdata = '0;
    seen_wb_addr = '0; seen_fill_addr = '0; seen_wb_data = '0; got_rdata = '0; lat = 0;
    proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0;
    proc_addr = '0; proc_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    model_clear();
    world[28'h0000010] = A5;
    fork compare_loop(); join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_proc_ready", 128'(proc_ready), 128'd0);
    chk("rst_proc_rdata", proc_rdata, 128'd0);
    chk("rst_mem_read", 128'(mem_read), 128'd0);
    chk("rst_mem_write", 128'(mem_write), 128'd0);
    chk("rst_mem_addr", 128'(mem_addr), 128'd0);
    chk("rst_mem_wdata", mem_wdata, 128'd0);
    proc_reset = 1'b0;
    chk_off = 1'b0;
    @(posedge clk); #1;

    do_req("cold_read", 1'b0, 1'b1, 28'h0000010, '0);
    chk("cold_read_fill_addr", 128'(seen_fill_addr), 128'h10);
    chk("cold_read_rdata", got_rdata, A5);

    do_req("repeat_read", 1'b0, 1'b1, 28'h0000010, '0);
    chk("repeat_read_lat", 128'(lat), 128'd2);

    do_req("write_clean_victim", 1'b1, 1'b0, 28'h0000018, D1);
    do_req("read_dirty_victim", 1'b0, 1'b1, 28'h0000028, '0);
    chk("dirty_wb_addr", 128'(seen_wb_addr), 128'h18);
    chk("dirty_wb_data", seen_wb_data, D1);
    chk("dirty_fill_addr", 128'(seen_fill_addr), 128'h28);
`ifdef L2_PERF_CNT_EN
    chk("perf_hit_cnt", 128'(hit_cnt), 128'd1);
    chk("perf_miss_cnt", 128'(miss_cnt), 128'd3);
`endif

    do_req("write_hit", 1'b1, 1'b0, 28'h0000028, D4);
    do_req("read_after_write_hit", 1'b0, 1'b1, 28'h0000028, '0);
    chk("read_after_write_hit_rdata", got_rdata, D4);
    do_req("write_invalid_line", 1'b1, 1'b0, 28'h0000021, D2);
    do_req("write_dirty_victim", 1'b1, 1'b0, 28'h0000031, D3);
    chk("write_dirty_wb_addr", 128'(seen_wb_addr), 128'h21);
    chk("write_dirty_wb_data", seen_wb_data, D2);
    do_req("read_write_both", 1'b1, 1'b1, 28'h0000031, D5);
    do_req("read_after_both", 1'b0, 1'b1, 28'h0000031, '0);
    chk("read_after_both_rdata", got_rdata, D5);
    do_req("refill_written_back", 1'b0, 1'b1, 28'h0000018, '0);
    chk("refill_written_back_rdata", got_rdata, D1);
    do_req("cold_read_idx7", 1'b0, 1'b1, 28'h0000007, '0);

    // Reset while a fill is outstanding; the transfer is never completed.
    exp_is_read = 1'b1; exp_wb_pending = 1'b0;
    exp_fill_pending = 1'b1; exp_fill_addr = 28'h000004F;
    req_active = 1'b1;
    proc_addr = 28'h000004F; proc_read = 1'b1;
    wc = 0; seen = 1'b0;
    while (!seen && wc < 20) begin
      @(negedge clk);
      seen = mem_read;
      @(posedge clk); #1;
      wc++;
    end
    chk("alloc_reached", 128'(seen), 128'd1);
    chk_off = 1'b1; proc_reset = 1'b1; proc_read = 1'b0; req_active = 1'b0;
    @(posedge clk); #1;
    chk("midrst_mem_read", 128'(mem_read), 128'd0);
    chk("midrst_mem_write", 128'(mem_write), 128'd0);
    chk("midrst_mem_addr", 128'(mem_addr), 128'd0);
    chk("midrst_proc_rdata", proc_rdata, 128'd0);
    chk("midrst_proc_ready", 128'(proc_ready), 128'd0);
`ifdef L2_PERF_CNT_EN
    chk("midrst_hit_cnt", 128'(hit_cnt), 128'd0);
    chk("midrst_miss_cnt", 128'(miss_cnt), 128'd0);
`endif
    proc_reset = 1'b0;
    model_clear();
    exp_fill_pending = 1'b0;
    @(posedge clk); #1;
    chk_off = 1'b0;
    @(posedge clk); #1;

    do_req("read_after_reset", 1'b0, 1'b1, 28'h000004F, '0);
    chk("read_after_reset_fill_addr", 128'(seen_fill_addr), 128'h4F);
    do_req("cached_lost_after_reset", 1'b0, 1'b1, 28'h0000010, '0);
    chk("cached_lost_after_reset_rdata", got_rdata, A5);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
